burst_accumulator_64bit: RTL and testbench

Sequential accumulation stage that consumes a burst of 64-bit operands over a valid/ready handshake and produces their modular sum plus a sticky unsigned-overflow flag. It sits directly downstream of the team's combinational 64-bit adder datapath and registers the running Sum/Cout across cycles. The finished result is presented on an output valid/ready handshake to the next consumer.

---
 rtl/burst_accumulator_64bit_pkg.sv | 13 +
 rtl/burst_accumulator_64bit_add_stage.sv | 14 +
 rtl/burst_accumulator_64bit.sv | 126 ++++++++++++
 tb/tb_burst_accumulator_64bit.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/burst_accumulator_64bit_pkg.sv
// Shared constants for the burst accumulator: default widths and FSM state encoding.
package burst_accumulator_64bit_pkg;

    localparam int DEFAULT_WIDTH = 64;
    localparam int DEFAULT_CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/burst_accumulator_64bit_add_stage.sv
// Combinational WIDTH-bit adder stage returning the modular sum and the carry-out.
module acc_add_stage #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

endmodule

// File: rtl/burst_accumulator_64bit.sv
// Burst accumulator: sums len operands over a valid/ready stream and presents the
// modular sum plus a sticky carry-out flag on an output valid/ready handshake.
module burst_accumulator_64bit
    import burst_accumulator_64bit_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             abort,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_ovf,
    output logic             busy,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] len_q, len_d;

    logic [WIDTH-1:0] add_sum;
    logic             add_cout;
    logic             xfer;
    logic             last_sample;

    acc_add_stage #(.WIDTH(WIDTH)) u_add (
        .a    (acc_q),
        .b    (in_data),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    assign xfer        = (state_q == ST_ACCUM) && in_valid;
    assign last_sample = (count_q == len_q - CNT_ONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            count_q <= '0;
            len_q   <= '0;
        end else begin
            // NOTE: non-blocking so every _q register samples its _d at the same edge.
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            count_q <= count_d;
            len_q   <= len_d;
        end
    end

    always_comb begin
        // NOTE: default assignment first so no branch leaves state_d unassigned (no latch).
        state_d = state_q;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  if (start) state_d = (len == '0) ? ST_DONE : ST_ACCUM;
                ST_ACCUM: if (in_valid && last_sample) state_d = ST_DONE;
                ST_DONE:  if (out_ready) state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Abort outranks a same-cycle start or transfer; count survives a normal completion.
    always_comb begin
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        count_d = count_q;
        len_d   = len_q;
        if (abort) begin
            acc_d   = '0;
            ovf_d   = 1'b0;
            count_d = '0;
        end else if ((state_q == ST_IDLE) && start) begin
            acc_d   = '0;
            ovf_d   = 1'b0;
            count_d = '0;
            len_d   = len;
        end else if (xfer) begin
            acc_d   = add_sum;
            ovf_d   = ovf_q | add_cout;
            count_d = count_q + CNT_ONE;
        end
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        out_sum   = '0;
        out_ovf   = 1'b0;
        case (state_q)
            ST_ACCUM: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                out_sum   = acc_q;
                out_ovf   = ovf_q;
            end
            default: ;
        endcase
    end

    assign count = count_q;

endmodule

// File: tb/tb_burst_accumulator_64bit.sv
// Self-checking bench: table vectors, hand-written corner sequences and random bursts
// compared against a wide-integer reference sum.
module tb_burst_accumulator_64bit;

    localparam int WIDTH = 64;
    localparam int CNT_W = 8;
    localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [CNT_W-1:0] len;
    logic             abort;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_ovf;
    logic             busy;
    logic [CNT_W-1:0] count;

    int checks   = 0;
    int failures = 0;

    logic [WIDTH-1:0] ops_q[$];
    bit               gaps;

    typedef struct {
        logic [CNT_W-1:0]         n;
        logic [3:0][WIDTH-1:0]    op;
        logic [WIDTH-1:0]         exp_sum;
        logic                     exp_ovf;
    } vec_t;

    vec_t vecs[6];

    burst_accumulator_64bit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_ovf   (out_ovf),
        .busy      (busy),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_b(input string name, input logic act, input logic exp);
        check(name, {{(WIDTH-1){1'b0}}, act}, {{(WIDTH-1){1'b0}}, exp});
    endtask

    task automatic check_cnt(input string name, input logic [CNT_W-1:0] act, input logic [CNT_W-1:0] exp);
        check(name, {{(WIDTH-CNT_W){1'b0}}, act}, {{(WIDTH-CNT_W){1'b0}}, exp});
    endtask

    // Reference: the true (unbounded) total; the carry flag is set iff it reaches 2^WIDTH.
    function automatic void model(output logic [WIDTH-1:0] s, output logic o);
        logic [WIDTH+CNT_W-1:0] total;
        total = '0;
        foreach (ops_q[i]) total += {{CNT_W{1'b0}}, ops_q[i]};
        s = total[WIDTH-1:0];
        o = (total[WIDTH+CNT_W-1:WIDTH] != '0);
    endfunction

    task automatic check_idle_outputs(input string tag);
        check_b({tag, " in_ready"}, in_ready, 1'b0);
        check_b({tag, " out_valid"}, out_valid, 1'b0);
        check_b({tag, " busy"}, busy, 1'b0);
        check({tag, " out_sum"}, out_sum, '0);
        check_b({tag, " out_ovf"}, out_ovf, 1'b0);
    endtask

    // Starts a burst of ops_q.size() operands and returns once out_valid is seen.
    task automatic run_burst(input string tag, output logic [WIDTH-1:0] got_sum, output logic got_ovf);
        int               idx;
        int               cyc;
        bit               xfer;
        logic [WIDTH-1:0] es;
        logic             eo;
        logic [CNT_W-1:0] n;
        idx = 0;
        cyc = 0;
        n   = CNT_W'(ops_q.size());
        model(es, eo);
        start = 1'b1;
        len   = n;
        step();
        start = 1'b0;
        if (n == '0) check_b({tag, " len0 latency"}, out_valid, 1'b1);
        while (!out_valid && cyc < 2000) begin
            in_valid = (idx < ops_q.size()) && (!gaps || $urandom_range(0, 2) != 0);
            in_data  = (idx < ops_q.size()) ? ops_q[idx] : '0;
            xfer     = in_valid && in_ready;
            step();
            if (xfer) begin
                idx++;
                if (idx == ops_q.size()) check_b({tag, " latency"}, out_valid, 1'b1);
            end
            cyc++;
        end
        in_valid = 1'b0;
        check_b({tag, " out_valid"}, out_valid, 1'b1);
        check({tag, " sum"}, out_sum, es);
        check_b({tag, " ovf"}, out_ovf, eo);
        check_cnt({tag, " count"}, count, n);
        check_b({tag, " in_ready in DONE"}, in_ready, 1'b0);
        check({tag, " accepted"}, WIDTH'(idx), WIDTH'(ops_q.size()));
        got_sum = out_sum;
        got_ovf = out_ovf;
    endtask

    task automatic release_out(input string tag, input int delay);
        logic [CNT_W-1:0] n;
        n = CNT_W'(ops_q.size());
        for (int i = 0; i < delay; i++) step();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check_b({tag, " idle busy"}, busy, 1'b0);
        check_b({tag, " idle out_valid"}, out_valid, 1'b0);
        check_cnt({tag, " count kept"}, count, n);
    endtask

    initial begin
        logic [WIDTH-1:0] gs;
        logic             go;

        vecs[0] = '{n: 8'd2, op: {64'd0, 64'd0, 64'd123, 64'd123}, exp_sum: 64'd246, exp_ovf: 1'b0};
        vecs[1] = '{n: 8'd3, op: {64'd0, 64'd5, 64'd1, ONES},      exp_sum: 64'd5,   exp_ovf: 1'b1};
        vecs[2] = '{n: 8'd0, op: {64'd0, 64'd0, 64'd0, 64'd0},     exp_sum: 64'd0,   exp_ovf: 1'b0};
        vecs[3] = '{n: 8'd1, op: {64'd0, 64'd0, 64'd0, 64'd42},    exp_sum: 64'd42,  exp_ovf: 1'b0};
        vecs[4] = '{n: 8'd4, op: {64'd0, 64'd2, ONES, ONES},       exp_sum: 64'd0,   exp_ovf: 1'b1};
        vecs[5] = '{n: 8'd2, op: {64'd0, 64'd0, 64'd1, ONES - 64'd1}, exp_sum: ONES, exp_ovf: 1'b0};

        rst_n     = 1'b0;
        start     = 1'b0;
        len       = '0;
        abort     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        gaps      = 1'b0;

        #3;
        check_idle_outputs("reset");
        check_cnt("reset count", count, '0);
        step();
        @(negedge clk);
        rst_n = 1'b1;
        step();

        for (int v = 0; v < 6; v++) begin
            ops_q.delete();
            for (int k = 0; k < int'(vecs[v].n); k++) ops_q.push_back(vecs[v].op[k]);
            gaps = v[0];
            run_burst($sformatf("vec%0d", v), gs, go);
            check($sformatf("vec%0d table sum", v), gs, vecs[v].exp_sum);
            check_b($sformatf("vec%0d table ovf", v), go, vecs[v].exp_ovf);
            release_out($sformatf("vec%0d", v), 1);
        end

        // Result held while out_ready is low; a start during DONE is ignored.
        ops_q = '{64'd10, 64'd20, 64'd30, 64'd40};
        gaps  = 1'b1;
        run_burst("hold", gs, go);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                start = 1'b1;
                len   = 8'd9;
            end
            step();
            start = 1'b0;
            check_b($sformatf("hold%0d out_valid", i), out_valid, 1'b1);
            check($sformatf("hold%0d sum", i), out_sum, 64'd100);
            check_cnt($sformatf("hold%0d count", i), count, 8'd4);
        end
        release_out("hold", 0);

        // Minimum turnaround of len+2 cycles with out_ready held high.
        out_ready = 1'b1;
        start     = 1'b1;
        len       = 8'd3;
        in_valid  = 1'b1;
        in_data   = 64'd1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        in_valid = 1'b0;
        check_b("turnaround out_valid", out_valid, 1'b1);
        check("turnaround sum", out_sum, 64'd3);
        step();
        check_b("turnaround idle", busy, 1'b0);
        out_ready = 1'b0;

        // Abort in the same cycle as a transfer.
        start = 1'b1;
        len   = 8'd4;
        step();
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = 64'd5;
        step();
        in_data = 64'd6;
        step();
        in_data = 64'd7;
        abort   = 1'b1;
        step();
        abort    = 1'b0;
        in_valid = 1'b0;
        check_idle_outputs("abort");
        check_cnt("abort count", count, '0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_b($sformatf("abort quiet%0d out_valid", i), out_valid, 1'b0);
        end
        ops_q = '{64'd1, 64'd2};
        gaps  = 1'b0;
        run_burst("post abort", gs, go);
        check("post abort sum3", gs, 64'd3);
        release_out("post abort", 0);

        // start and abort together in IDLE: stay idle.
        start = 1'b1;
        abort = 1'b1;
        len   = 8'd3;
        step();
        start = 1'b0;
        abort = 1'b0;
        check_b("start+abort busy", busy, 1'b0);
        step();
        check_b("start+abort busy later", busy, 1'b0);
        check_b("start+abort in_ready", in_ready, 1'b0);

        // Asynchronous reset between edges while in ACCUM.
        start = 1'b1;
        len   = 8'd4;
        step();
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = 64'd9;
        step();
        in_valid = 1'b0;
        check_b("pre-reset busy", busy, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("async reset");
        check_cnt("async reset count", count, '0);
        step();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        ops_q = '{64'd7, 64'd8};
        run_burst("post reset", gs, go);
        check("post reset sum15", gs, 64'd15);
        release_out("post reset", 0);

        // Random bursts against the reference model.
        for (int b = 0; b < 25; b++) begin
            int n;
            int mode;
            n    = $urandom_range(0, 24);
            mode = $urandom_range(0, 2);
            ops_q.delete();
            for (int k = 0; k < n; k++) begin
                case (mode)
                    0:       ops_q.push_back({$urandom, $urandom});
                    1:       ops_q.push_back({32'hFFFF_FFFF, $urandom});
                    default: ops_q.push_back({32'd0, 16'd0, 16'($urandom)});
                endcase
            end
            gaps = ($urandom_range(0, 1) == 1);
            run_burst($sformatf("rand%0d", b), gs, go);
            release_out($sformatf("rand%0d", b), $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
